// File: rtl/seg_pkg.sv
// Seven-segment decode tables and helpers shared by the scan-capture block.
// Patterns are active-low {g,f,e,d,c,b,a}.
package seg_pkg;

  // Index n holds the pattern for hex digit n.
  localparam logic [15:0][6:0] SEG_HEX = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef struct packed {
    logic [3:0] nib;
    logic       hit;
    logic       blank;
  } seg_dec_t;

  function automatic seg_dec_t seg_decode(input logic [6:0] pat);
    seg_dec_t d;
    d       = '0;
    d.blank = (pat == SEG_BLANK);
    for (int i = 0; i < 16; i++) begin
      if (!d.hit && pat == SEG_HEX[i]) begin
        d.hit = 1'b1;
        d.nib = 4'(i);
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational 7-bit segment pattern to hex nibble / blank classifier.
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [6:0] pattern,
  output seg_dec_t   dec
);

  assign dec = seg_decode(pattern);

endmodule

// File: rtl/seg_scan_capture.sv
// Recovers hex digits + DP from a scanned active-low seven-segment bus.
// Build option SEG_SYNC_EN adds a 2-flop input synchronizer for an asynchronous bus.
module seg_scan_capture
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    segment_in,
  input  logic [NUM_DIGITS-1:0]         anode_in,
  input  logic                          clear_i,
  output logic [4*NUM_DIGITS-1:0]       digits_o,
  output logic [NUM_DIGITS-1:0]         dp_o,
  output logic [NUM_DIGITS-1:0]         digit_valid_o,
  output logic                          frame_valid_o,
  output logic                          update_o,
  output logic [$clog2(NUM_DIGITS)-1:0] update_idx_o,
  output logic                          err_o
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int IDX_W = $clog2(NUM_DIGITS);

  logic [NUM_DIGITS-1:0] an_d, s_an;
  logic [7:0]            seg_d, s_seg;

`ifdef SEG_SYNC_EN
  logic [NUM_DIGITS-1:0] an_m, an_q;
  logic [7:0]            seg_m, seg_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_m  <= '1;
      an_q  <= '1;
      seg_m <= '1;
      seg_q <= '1;
    end else begin
      an_m  <= anode_in;
      an_q  <= an_m;
      seg_m <= segment_in;
      seg_q <= seg_m;
    end
  end

  assign an_d  = an_q;
  assign seg_d = seg_q;
`else
  assign an_d  = anode_in;
  assign seg_d = segment_in;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_an  <= '1;
      s_seg <= '1;
    end else begin
      s_an  <= an_d;
      s_seg <= seg_d;
    end
  end

  // One-cold index encoder: zero or several low anodes mean no active digit.
  logic             found, multi, active;
  logic [IDX_W-1:0] act_idx;

  always_comb begin
    found   = 1'b0;
    multi   = 1'b0;
    act_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!s_an[i]) begin
        if (found) multi = 1'b1;
        found   = 1'b1;
        act_idx = IDX_W'(i);
      end
    end
    active = found & ~multi;
  end

  logic             stable, cap;
  logic [CNT_W-1:0] cnt;

  // The incoming sample is compared with the held one, so a held bus
  // reaches the capture threshold STABLE_CYCLES+1 edges after it changes.
  assign stable = active && (an_d == s_an) && (seg_d == s_seg);
  assign cap    = stable && (cnt == CNT_W'(STABLE_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              cnt <= '0;
    else if (!stable)                        cnt <= '0;
    else if (cnt != CNT_W'(STABLE_CYCLES))   cnt <= cnt + 1'b1;
  end

  seg_dec_t dec;

  seg_pattern_decode u_dec (
    .pattern (s_seg[6:0]),
    .dec     (dec)
  );

  logic cap_ok, cap_bad;
  assign cap_ok  = cap && (dec.hit || dec.blank);
  assign cap_bad = cap && !dec.hit && !dec.blank;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      update_o     <= 1'b0;
      update_idx_o <= '0;
      err_o        <= 1'b0;
    end else begin
      update_o <= cap_ok;
      if (cap_ok) update_idx_o <= act_idx;
      if (cap_bad)      err_o <= 1'b1;
      else if (clear_i) err_o <= 1'b0;
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    logic sel;
    assign sel = (act_idx == IDX_W'(g));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        digits_o[4*g +: 4] <= '0;
        dp_o[g]            <= 1'b0;
        digit_valid_o[g]   <= 1'b0;
      end else begin
        if (cap_ok && sel) dp_o[g] <= ~s_seg[7];
        if (cap_ok && sel && dec.hit) begin
          digits_o[4*g +: 4] <= dec.nib;
          digit_valid_o[g]   <= 1'b1;
        end else if (clear_i) begin
          digit_valid_o[g]   <= 1'b0;
        end
      end
    end
  end

  assign frame_valid_o = &digit_valid_o;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed-vector bench for seg_scan_capture: scan table plus hand-written corner sequences.
module tb_seg_scan_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  segment_in;
  logic [3:0]  anode_in;
  logic        clear_i;
  logic [15:0] digits_o;
  logic [3:0]  dp_o, digit_valid_o;
  logic        frame_valid_o, update_o, err_o;
  logic [1:0]  update_idx_o;

  seg_scan_capture #(.NUM_DIGITS(4), .STABLE_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .segment_in(segment_in), .anode_in(anode_in),
    .clear_i(clear_i), .digits_o(digits_o), .dp_o(dp_o),
    .digit_valid_o(digit_valid_o), .frame_valid_o(frame_valid_o),
    .update_o(update_o), .update_idx_o(update_idx_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int         n_pass = 0, n_total = 0;
  int         upd_cnt = 0;
  logic [1:0] last_idx = '0;

  always @(negedge clk) begin
    if (update_o) begin
      upd_cnt  = upd_cnt + 1;
      last_idx = update_idx_o;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Called just after a rising edge; returns just after the n-th following edge.
  task automatic hold(input logic [3:0] an, input logic [7:0] seg, input int n);
    anode_in   = an;
    segment_in = seg;
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0]  an;
    logic [7:0]  seg;
    int          n;
    logic [15:0] e_dig;
    logic [3:0]  e_dp;
    logic [3:0]  e_val;
    logic        e_err;
    int          e_upd;
    logic [1:0]  e_idx;
  } vec_t;

  vec_t vt [10];

  initial begin
    int u0;
    vt[0] = '{4'hE, 8'hF9, 20, 16'h0041, 4'b0000, 4'b0011, 1'b0, 1, 2'd0};
    vt[1] = '{4'hD, 8'hB0, 20, 16'h0031, 4'b0000, 4'b0011, 1'b0, 1, 2'd1};
    vt[2] = '{4'hB, 8'h88, 20, 16'h0A31, 4'b0000, 4'b0111, 1'b0, 1, 2'd2};
    vt[3] = '{4'h7, 8'h0E, 20, 16'hFA31, 4'b1000, 4'b1111, 1'b0, 1, 2'd3};
    vt[4] = '{4'hF, 8'hFF,  3, 16'hFA31, 4'b1000, 4'b1111, 1'b0, 0, 2'd0};
    vt[5] = '{4'h7, 8'h0E, 20, 16'hFA31, 4'b1000, 4'b1111, 1'b0, 1, 2'd3};
    vt[6] = '{4'hD, 8'hFF, 20, 16'hFA31, 4'b1000, 4'b1111, 1'b0, 1, 2'd1};
    vt[7] = '{4'hD, 8'h7F, 20, 16'hFA31, 4'b1010, 4'b1111, 1'b0, 1, 2'd1};
    vt[8] = '{4'hE, 8'hFE, 20, 16'hFA31, 4'b1010, 4'b1111, 1'b1, 0, 2'd0};
    vt[9] = '{4'hC, 8'hA4, 20, 16'hFA31, 4'b1010, 4'b1111, 1'b1, 0, 2'd0};

    // Reset with a random bus
    rst_n = 1'b0; clear_i = 1'b0;
    anode_in = 4'($urandom); segment_in = 8'($urandom);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_digits", digits_o, 0);
    chk("rst_dp", dp_o, 0);
    chk("rst_valid", digit_valid_o, 0);
    chk("rst_frame", frame_valid_o, 0);
    chk("rst_update", update_o, 0);
    chk("rst_idx", update_idx_o, 0);
    chk("rst_err", err_o, 0);
    rst_n = 1'b1;
    hold(4'hF, 8'hFF, 20);
    chk("idle_no_update", upd_cnt, 0);

    // Exact capture latency on digit0 = 2
    hold(4'hE, 8'hA4, 16);
    chk("lat_early", update_o, 0);
    hold(4'hE, 8'hA4, 1);
    chk("lat_update", update_o, 1);
    chk("lat_idx", update_idx_o, 0);
    chk("lat_digit0", digits_o[3:0], 4'h2);
    chk("lat_dp0", dp_o[0], 0);
    hold(4'hE, 8'hA4, 6);
    chk("lat_once", upd_cnt, 1);

    // Glitch at the end of a 15-cycle run must not capture
    u0 = upd_cnt;
    hold(4'hD, 8'h99, 15);
    hold(4'hD, 8'h98, 1);
    hold(4'hF, 8'hFF, 3);
    chk("glitch_no_cap", upd_cnt - u0, 0);
    hold(4'hD, 8'h99, 20);
    chk("glitch_digit1", digits_o[7:4], 4'h4);
    chk("glitch_valid", digit_valid_o, 4'b0011);

    for (int i = 0; i < 10; i++) begin
      u0 = upd_cnt;
      hold(vt[i].an, vt[i].seg, vt[i].n);
      chk($sformatf("v%0d_digits", i), digits_o, vt[i].e_dig);
      chk($sformatf("v%0d_dp", i), dp_o, vt[i].e_dp);
      chk($sformatf("v%0d_valid", i), digit_valid_o, vt[i].e_val);
      chk($sformatf("v%0d_frame", i), frame_valid_o, &vt[i].e_val);
      chk($sformatf("v%0d_err", i), err_o, vt[i].e_err);
      chk($sformatf("v%0d_upd", i), upd_cnt - u0, vt[i].e_upd);
      if (vt[i].e_upd != 0) chk($sformatf("v%0d_idx", i), last_idx, vt[i].e_idx);
    end

    // clear_i drops valid/err but keeps digits and dp
    hold(4'hF, 8'hFF, 2);
    clear_i = 1'b1;
    @(posedge clk); #1;
    clear_i = 1'b0;
    chk("clr_valid", digit_valid_o, 0);
    chk("clr_err", err_o, 0);
    chk("clr_digits", digits_o, 16'hFA31);
    chk("clr_dp", dp_o, 4'b1010);

    // clear_i in the same cycle as digit2's capture
    hold(4'hE, 8'hF9, 20);
    chk("pre_coinc_valid", digit_valid_o, 4'b0001);
    hold(4'hB, 8'h88, 16);
    clear_i = 1'b1;
    @(posedge clk); #1;
    clear_i = 1'b0;
    chk("coinc_update", update_o, 1);
    chk("coinc_valid", digit_valid_o, 4'b0100);

    // Reset mid-run: everything back to zero, stability run restarts
    hold(4'hD, 8'hB0, 10);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_digits", digits_o, 0);
    chk("mid_rst_dp", dp_o, 0);
    chk("mid_rst_valid", digit_valid_o, 0);
    chk("mid_rst_err", err_o, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    u0 = upd_cnt;
    hold(4'hD, 8'hB0, 10);
    chk("mid_rst_no_partial", upd_cnt - u0, 0);
    hold(4'hD, 8'hB0, 10);
    chk("post_rst_cap", digits_o, 16'h0030);
    chk("post_rst_valid", digit_valid_o, 4'b0010);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
